// File: rtl/lcd_arb_pkg.sv
// Shared constants, FSM state type and helpers for the LCD time-share arbiter.
package lcd_arb_pkg;

    localparam int ROW_W   = 64;
    localparam int MASK_W  = 16;
    localparam int MAX_REQ = 8;

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    // Index of the set bit of a one-hot vector; zero when no bit is set.
    function automatic logic [2:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx |= 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lcd_arbiter_if.sv
// Client request/data bundle and selected display outputs of the LCD arbiter.
interface lcd_arbiter_if #(
    parameter int NREQ = 4
);
    import lcd_arb_pkg::*;

    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        urg;
    logic [NREQ*ROW_W-1:0]  f1_in;
    logic [NREQ*ROW_W-1:0]  f2_in;
    logic [NREQ*MASK_W-1:0] m1_in;
    logic [NREQ*MASK_W-1:0] m2_in;
    logic [ROW_W-1:0]       f1;
    logic [ROW_W-1:0]       f2;
    logic [MASK_W-1:0]      m1;
    logic [MASK_W-1:0]      m2;
    logic [NREQ-1:0]        gnt;
    logic                   busy;

    modport master (
        output req, urg, f1_in, f2_in, m1_in, m2_in,
        input  f1, f2, m1, m2, gnt, busy
    );

    modport slave (
        input  req, urg, f1_in, f2_in, m1_in, m2_in,
        output f1, f2, m1, m2, gnt, busy
    );

endinterface

// File: rtl/lcd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of c scanning cyclically from ptr+1.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] c,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic            valid
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic              found;
    int                start;
    int                idx;

    // Doubling the vector turns the cyclic scan into a plain priority scan.
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        start = (int'(ptr) >= NREQ - 1) ? 0 : int'(ptr) + 1;
        dbl   = {c, c};
        rot   = NREQ'(dbl >> start);
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                idx   = (start + j >= NREQ) ? start + j - NREQ : start + j;
            end
        end
        if (found) pick = NREQ'(1) << idx;
        valid = found;
    end

endmodule

// File: rtl/lcd_arbiter.sv
// Time-shares the two-row hex LCD among NREQ clients: urgent pre-emption,
// round-robin rotation after DWELL cycles, registered output mux.
module lcd_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DWELL = 100_000_000,
    parameter int CW    = $clog2(DWELL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    lcd_arbiter_if.slave  bus
);

    localparam int IW = $clog2(NREQ);

    state_t          state, state_n;
    logic [NREQ-1:0] gnt, gnt_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [IW-1:0]   ptr, ptr_n;

    logic [NREQ-1:0] urg_set;
    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] pick;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   gnt_idx;
    logic            owner_req;
    logic            preempt;
    logic            take;

    assign urg_set   = bus.req & bus.urg;
    assign cand      = (|urg_set) ? urg_set : bus.req;
    assign owner_req = |(bus.req & gnt);
    assign preempt   = (|urg_set) && !(|(urg_set & gnt));
    assign pick_idx  = IW'(onehot2idx(MAX_REQ'(pick)));
    assign gnt_idx   = IW'(onehot2idx(MAX_REQ'(gnt)));

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .c     (cand),
        .ptr   (ptr),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            cnt   <= '0;
            ptr   <= IW'(NREQ - 1);
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
        end
    end

    // Switch reasons in priority order: owner dropped, urgent pre-empt, dwell expiry.
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        cnt_n   = cnt;
        ptr_n   = ptr;
        take    = 1'b0;
        case (state)
            IDLE: take = pick_valid;
            SHOW: begin
                cnt_n = cnt - CW'(1);
                if (!owner_req) begin
                    if (pick_valid) begin
                        take = 1'b1;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        cnt_n   = '0;
                    end
                end else if (preempt) begin
                    take = 1'b1;
                end else if (cnt == '0) begin
                    if (|(cand & ~gnt)) take = 1'b1;
                    else                cnt_n = CW'(DWELL - 1);
                end
            end
            default: ;
        endcase
        if (take) begin
            state_n = SHOW;
            gnt_n   = pick;
            ptr_n   = pick_idx;
            cnt_n   = CW'(DWELL - 1);
        end
    end

    logic [ROW_W-1:0]  f1_a [NREQ];
    logic [ROW_W-1:0]  f2_a [NREQ];
    logic [MASK_W-1:0] m1_a [NREQ];
    logic [MASK_W-1:0] m2_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign f1_a[g] = bus.f1_in[g*ROW_W +: ROW_W];
        assign f2_a[g] = bus.f2_in[g*ROW_W +: ROW_W];
        assign m1_a[g] = bus.m1_in[g*MASK_W +: MASK_W];
        assign m2_a[g] = bus.m2_in[g*MASK_W +: MASK_W];
    end

    logic [ROW_W-1:0]  row1, row2;
    logic [MASK_W-1:0] mask1, mask2;

    // Owner data flows through live; while idle the rows hold and the masks blank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row1  <= '0;
            row2  <= '0;
            mask1 <= '0;
            mask2 <= '0;
        end else if (|gnt) begin
            row1  <= f1_a[gnt_idx];
            row2  <= f2_a[gnt_idx];
            mask1 <= m1_a[gnt_idx];
            mask2 <= m2_a[gnt_idx];
        end else begin
            mask1 <= '0;
            mask2 <= '0;
        end
    end

    assign bus.f1   = row1;
    assign bus.f2   = row2;
    assign bus.m1   = mask1;
    assign bus.m2   = mask2;
    assign bus.gnt  = gnt;
    assign bus.busy = |gnt;

endmodule
